vram_arbiter: RTL and testbench

- Arbitrates a single-port synchronous frame-buffer RAM between two requesters on the pixel clock domain.
  - Display fetch path: driven by `video_on` and `x_loc`/`y_loc` from `vga_sync`.
  - Drawing-engine write port: valid/ready handshake.
- Display reads have absolute priority during active video.
- Writes are buffered in a small FIFO and drained only during blanking.
- Returned pixel data feeds `make_current_pixel` at a fixed latency.

---
 rtl/vram_arbiter.sv | 106 ++++++++++
 tb/tb_vram_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - frame-buffer RAM arbiter: display reads during active video, buffered writes drained in blanking
module vram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int H_ACTIVE   = 640,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk_d,
    input  logic                         rst_n,
    input  logic                         video_on,
    input  logic [9:0]                   x_loc,
    input  logic [9:0]                   y_loc,
    input  logic                         wr_valid,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_we,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [DATA_W-1:0]            pix_data,
    output logic                         pix_valid
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;
    logic              r_run;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_v1;
    logic              r_rd_v2;
    logic [DATA_W-1:0] r_pix_data;
    logic              r_pix_valid;

    logic [PTR_W:0]    w_level;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_row_base;
    logic [ADDR_W-1:0] w_disp_addr;

    // Extra pointer bit distinguishes full from empty.
    assign w_level     = r_wptr - r_rptr;
    assign w_ready     = r_run && (w_level < (PTR_W+1)'(FIFO_DEPTH));
    assign w_push      = wr_valid && w_ready;
    assign w_pop       = !video_on && (w_level != '0);
    assign w_row_base  = ADDR_W'(32'(y_loc) * 32'(H_ACTIVE));
    assign w_disp_addr = w_row_base + ADDR_W'(x_loc);

    assign wr_ready   = w_ready;
    assign fifo_level = w_level;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign pix_data   = r_pix_data;
    assign pix_valid  = r_pix_valid;

    always_ff @(posedge clk_d) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[PTR_W-1:0]] <= wr_addr;
            r_fifo_data[r_wptr[PTR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_run       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rd_v1     <= 1'b0;
            r_rd_v2     <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;

            // Active video always owns the RAM; the FIFO waits for blanking.
            if (video_on) begin
                r_mem_addr <= w_disp_addr;
                r_mem_we   <= 1'b0;
            end else if (w_pop) begin
                r_mem_addr  <= r_fifo_addr[r_rptr[PTR_W-1:0]];
                r_mem_wdata <= r_fifo_data[r_rptr[PTR_W-1:0]];
                r_mem_we    <= 1'b1;
            end else begin
                r_mem_we <= 1'b0;
            end

            // Address register, RAM read register, then pixel register.
            r_rd_v1     <= video_on;
            r_rd_v2     <= r_rd_v1;
            r_pix_valid <= r_rd_v2;
            if (r_rd_v2) r_pix_data <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed table and sequence bench for vram_arbiter
module tb_vram_arbiter;
    logic        clk_d = 1'b0;
    logic        rst_n;
    logic        video_on;
    logic [9:0]  x_loc, y_loc;
    logic        wr_valid;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic [2:0]  fifo_level;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] pix_data;
    logic        pix_valid;

    int checks = 0;
    int failures = 0;

    logic [11:0] ram [4096];

    typedef struct {
        logic        von;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        wv;
        logic [18:0] wa;
        logic [11:0] wd;
        logic        e_we;
        logic [18:0] e_addr;
        logic [11:0] e_wdata;
        logic [2:0]  e_lvl;
        logic        e_rdy;
        logic        e_pv;
        logic [11:0] e_pd;
    } vec_t;

    vec_t tbl [10];

    vram_arbiter dut (
        .clk_d(clk_d), .rst_n(rst_n), .video_on(video_on), .x_loc(x_loc), .y_loc(y_loc),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .fifo_level(fifo_level), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
    );

    always #5 clk_d = ~clk_d;

    always @(posedge clk_d) begin
        if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    task automatic step(input string name, input logic von, input logic wv,
                        input logic [18:0] wa, input logic [11:0] wd,
                        input logic e_we, input logic [18:0] e_addr, input logic [11:0] e_wdata,
                        input logic [2:0] e_lvl, input logic e_rdy);
        video_on = von; x_loc = '0; y_loc = '0;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        tick();
        chk({name, ".we"},    32'(mem_we),     32'(e_we));
        chk({name, ".addr"},  32'(mem_addr),   32'(e_addr));
        chk({name, ".wdata"}, 32'(mem_wdata),  32'(e_wdata));
        chk({name, ".level"}, 32'(fifo_level), 32'(e_lvl));
        chk({name, ".ready"}, 32'(wr_ready),   32'(e_rdy));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        ram[1285] = 12'hABC;
        ram[1286] = 12'h123;
        ram[1287] = 12'h456;
        ram[0]    = 12'h789;

        //           von x    y    wv wa  wd      we addr    wdata   lvl rdy pv pd
        tbl[0] = '{1'b1, 10'd5,    10'd2,    1'b0, 19'd0,  12'h000, 1'b0, 19'd1285,   12'h000, 3'd0, 1'b1, 1'b0, 12'h000};
        tbl[1] = '{1'b1, 10'd6,    10'd2,    1'b1, 19'd10, 12'h111, 1'b0, 19'd1286,   12'h000, 3'd1, 1'b1, 1'b0, 12'h000};
        tbl[2] = '{1'b1, 10'd7,    10'd2,    1'b1, 19'd11, 12'h222, 1'b0, 19'd1287,   12'h000, 3'd2, 1'b1, 1'b1, 12'hABC};
        tbl[3] = '{1'b1, 10'd0,    10'd0,    1'b1, 19'd12, 12'h333, 1'b0, 19'd0,      12'h000, 3'd3, 1'b1, 1'b1, 12'h123};
        tbl[4] = '{1'b0, 10'd0,    10'd0,    1'b0, 19'd0,  12'h000, 1'b1, 19'd10,     12'h111, 3'd2, 1'b1, 1'b1, 12'h456};
        tbl[5] = '{1'b0, 10'd0,    10'd0,    1'b0, 19'd0,  12'h000, 1'b1, 19'd11,     12'h222, 3'd1, 1'b1, 1'b1, 12'h789};
        tbl[6] = '{1'b0, 10'd0,    10'd0,    1'b0, 19'd0,  12'h000, 1'b1, 19'd12,     12'h333, 3'd0, 1'b1, 1'b0, 12'h789};
        tbl[7] = '{1'b0, 10'd0,    10'd0,    1'b0, 19'd0,  12'h000, 1'b0, 19'd12,     12'h333, 3'd0, 1'b1, 1'b0, 12'h789};
        tbl[8] = '{1'b1, 10'd639,  10'd479,  1'b0, 19'd0,  12'h000, 1'b0, 19'd307199, 12'h333, 3'd0, 1'b1, 1'b0, 12'h789};
        tbl[9] = '{1'b1, 10'd1023, 10'd1023, 1'b0, 19'd0,  12'h000, 1'b0, 19'd131455, 12'h333, 3'd0, 1'b1, 1'b0, 12'h789};

        rst_n = 1'b0; video_on = 1'b0; x_loc = '0; y_loc = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        #2;
        chk("rst.we",    32'(mem_we),     32'd0);
        chk("rst.addr",  32'(mem_addr),   32'd0);
        chk("rst.level", 32'(fifo_level), 32'd0);
        chk("rst.ready", 32'(wr_ready),   32'd0);
        chk("rst.pv",    32'(pix_valid),  32'd0);
        chk("rst.pd",    32'(pix_data),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("run.ready", 32'(wr_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            video_on = tbl[i].von; x_loc = tbl[i].x; y_loc = tbl[i].y;
            wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            tick();
            chk($sformatf("v%0d.we", i),    32'(mem_we),     32'(tbl[i].e_we));
            chk($sformatf("v%0d.addr", i),  32'(mem_addr),   32'(tbl[i].e_addr));
            chk($sformatf("v%0d.wdata", i), 32'(mem_wdata),  32'(tbl[i].e_wdata));
            chk($sformatf("v%0d.level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
            chk($sformatf("v%0d.ready", i), 32'(wr_ready),   32'(tbl[i].e_rdy));
            chk($sformatf("v%0d.pv", i),    32'(pix_valid),  32'(tbl[i].e_pv));
            chk($sformatf("v%0d.pd", i),    32'(pix_data),   32'(tbl[i].e_pd));
        end

        // Full FIFO: fifth request waits until the first drain frees a slot.
        step("full0", 1, 1, 19'd20, 12'hA00, 0, 19'd0,  12'h333, 3'd1, 1);
        step("full1", 1, 1, 19'd21, 12'hA01, 0, 19'd0,  12'h333, 3'd2, 1);
        step("full2", 1, 1, 19'd22, 12'hA02, 0, 19'd0,  12'h333, 3'd3, 1);
        step("full3", 1, 1, 19'd23, 12'hA03, 0, 19'd0,  12'h333, 3'd4, 0);
        step("full4", 1, 1, 19'd24, 12'hA04, 0, 19'd0,  12'h333, 3'd4, 0);
        step("full5", 0, 1, 19'd24, 12'hA04, 1, 19'd20, 12'hA00, 3'd3, 1);
        step("full6", 0, 1, 19'd24, 12'hA04, 1, 19'd21, 12'hA01, 3'd3, 1);
        step("full7", 0, 0, 19'd0,  12'h000, 1, 19'd22, 12'hA02, 3'd2, 1);
        step("full8", 0, 0, 19'd0,  12'h000, 1, 19'd23, 12'hA03, 3'd1, 1);
        step("full9", 0, 0, 19'd0,  12'h000, 1, 19'd24, 12'hA04, 3'd0, 1);
        step("fullA", 0, 0, 19'd0,  12'h000, 0, 19'd24, 12'hA04, 3'd0, 1);

        // Drain interrupted by a one-cycle blanking gap.
        step("intr0", 1, 1, 19'd30, 12'hB00, 0, 19'd0,  12'hA04, 3'd1, 1);
        step("intr1", 1, 1, 19'd31, 12'hB01, 0, 19'd0,  12'hA04, 3'd2, 1);
        step("intr2", 0, 0, 19'd0,  12'h000, 1, 19'd30, 12'hB00, 3'd1, 1);
        step("intr3", 1, 0, 19'd0,  12'h000, 0, 19'd0,  12'hB00, 3'd1, 1);
        step("intr4", 0, 0, 19'd0,  12'h000, 1, 19'd31, 12'hB01, 3'd0, 1);
        step("intr5", 0, 0, 19'd0,  12'h000, 0, 19'd31, 12'hB01, 3'd0, 1);

        // Simultaneous push and pop keep the level and the order.
        step("ovl0", 1, 1, 19'd40, 12'hC00, 0, 19'd0, 12'hB01, 3'd1, 1);
        step("ovl1", 1, 1, 19'd41, 12'hC01, 0, 19'd0, 12'hB01, 3'd2, 1);
        for (int i = 0; i < 5; i++)
            step($sformatf("ovl_pp%0d", i), 0, 1, 19'(42 + i), 12'(12'hC02 + i),
                 1, 19'(40 + i), 12'(12'hC00 + i), 3'd2, 1);
        step("ovl7", 0, 0, 19'd0, 12'h000, 1, 19'd45, 12'hC05, 3'd1, 1);
        step("ovl8", 0, 0, 19'd0, 12'h000, 1, 19'd46, 12'hC06, 3'd0, 1);

        // Asynchronous reset in the middle of a drain.
        step("rd0", 1, 1, 19'd50, 12'hD00, 0, 19'd0,  12'hC06, 3'd1, 1);
        step("rd1", 1, 1, 19'd51, 12'hD01, 0, 19'd0,  12'hC06, 3'd2, 1);
        step("rd2", 1, 1, 19'd52, 12'hD02, 0, 19'd0,  12'hC06, 3'd3, 1);
        step("rd3", 0, 0, 19'd0,  12'h000, 1, 19'd50, 12'hD00, 3'd2, 1);
        rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 19'd60; wr_data = 12'hE00;
        #1;
        chk("rstmid.we",    32'(mem_we),     32'd0);
        chk("rstmid.level", 32'(fifo_level), 32'd0);
        chk("rstmid.ready", 32'(wr_ready),   32'd0);
        chk("rstmid.addr",  32'(mem_addr),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel.ready0", 32'(wr_ready), 32'd0);
        tick();
        chk("rel.we1",    32'(mem_we),     32'd0);
        chk("rel.level1", 32'(fifo_level), 32'd0);
        chk("rel.ready1", 32'(wr_ready),   32'd1);
        wr_valid = 1'b0;
        tick();
        chk("rel.we2",    32'(mem_we),     32'd0);
        chk("rel.level2", 32'(fifo_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
